// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store initiator for the L1 data port.
// One op in flight; request held stable across dmem_wait.
module dmem_lsu #(
  parameter int unsigned WAIT_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        lsu_valid,
  output logic        lsu_ready,
  input  logic        lsu_we,
  input  logic [2:0]  lsu_funct3,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  output logic        lsu_done,
  output logic        lsu_err,
  output logic [31:0] lsu_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wd,
  output logic [3:0]  dmem_mask,
  input  logic [31:0] dmem_rd,
  input  logic        dmem_wait
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] cnt_q, cnt_d;
  logic        req_d, done_d, err_d;
  logic [31:0] addr_d, wd_d, rdata_d;
  logic [3:0]  mask_d;

  logic [3:0]  mask_c;
  logic [31:0] wd_c, ld_c;
  logic [7:0]  byte_c;
  logic [15:0] half_c;
  logic        ill_c, mis_c, bad_c, tmo_c;

  assign lsu_ready = ~rst_n | (state_q == IDLE);
  assign dmem_we   = rst_n & dmem_req & we_q & ~dmem_wait;

  // byte enables and lane-replicated store data
  always_comb begin
    mask_c = 4'b1111;
    wd_c   = lsu_wdata;
    unique case (lsu_funct3[1:0])
      2'b00: begin
        mask_c = 4'b0001 << lsu_addr[1:0];
        wd_c   = {4{lsu_wdata[7:0]}};
      end
      2'b01: begin
        mask_c = lsu_addr[1] ? 4'b1100 : 4'b0011;
        wd_c   = {2{lsu_wdata[15:0]}};
      end
      default: begin
        mask_c = 4'b1111;
        wd_c   = lsu_wdata;
      end
    endcase
  end

  // legality of the incoming request
  always_comb begin
    if (lsu_we)
      ill_c = lsu_funct3[2] |
              (lsu_funct3[1:0] == 2'b11);
    else
      ill_c = (lsu_funct3 == 3'b011) |
              (lsu_funct3[2:1] == 2'b11);
    mis_c = ((lsu_funct3[1:0] == 2'b01) &
             lsu_addr[0]) |
            ((lsu_funct3[1:0] == 2'b10) &
             (|lsu_addr[1:0]));
    bad_c = ill_c | mis_c;
  end

  // lane select and extension of load data
  always_comb begin
    byte_c = 8'(dmem_rd >> {dmem_addr[1:0], 3'b000});
    half_c = dmem_addr[1] ? dmem_rd[31:16]
                          : dmem_rd[15:0];
    unique case (f3_q)
      3'b000:  ld_c = {{24{byte_c[7]}}, byte_c};
      3'b001:  ld_c = {{16{half_c[15]}}, half_c};
      3'b100:  ld_c = {24'd0, byte_c};
      3'b101:  ld_c = {16'd0, half_c};
      default: ld_c = dmem_rd;
    endcase
  end

  assign tmo_c = (WAIT_TIMEOUT != 0) &&
                 (cnt_q == 32'(WAIT_TIMEOUT - 1));

  // next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    f3_d    = f3_q;
    cnt_d   = cnt_q;
    req_d   = dmem_req;
    addr_d  = dmem_addr;
    wd_d    = dmem_wd;
    mask_d  = dmem_mask;
    done_d  = 1'b0;
    err_d   = 1'b0;
    rdata_d = 32'd0;
    unique case (state_q)
      IDLE: begin
        if (lsu_valid) begin
          we_d   = lsu_we;
          f3_d   = lsu_funct3;
          addr_d = lsu_addr;
          wd_d   = wd_c;
          mask_d = mask_c;
          if (bad_c) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else begin
            state_d = ACCESS;
            req_d   = 1'b1;
          end
        end
      end
      ACCESS: begin
        if (!dmem_wait) begin
          state_d = IDLE;
          req_d   = 1'b0;
          cnt_d   = 32'd0;
          done_d  = 1'b1;
          rdata_d = we_q ? 32'd0 : ld_c;
        end else if (tmo_c) begin
          state_d = IDLE;
          req_d   = 1'b0;
          cnt_d   = 32'd0;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      f3_q      <= 3'd0;
      cnt_q     <= 32'd0;
      dmem_req  <= 1'b0;
      dmem_addr <= 32'd0;
      dmem_wd   <= 32'd0;
      dmem_mask <= 4'd0;
      lsu_done  <= 1'b0;
      lsu_err   <= 1'b0;
      lsu_rdata <= 32'd0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      f3_q      <= f3_d;
      cnt_q     <= cnt_d;
      dmem_req  <= req_d;
      dmem_addr <= addr_d;
      dmem_wd   <= wd_d;
      dmem_mask <= mask_d;
      lsu_done  <= done_d;
      lsu_err   <= err_d;
      lsu_rdata <= rdata_d;
    end
  end

endmodule
